// File: rtl/sprite_config_scheduler.sv
// Sprite configuration bus scheduler: queues per-sprite xy/dxy write requests
// and issues one strobe per cycle with LFSR-derived position and velocity.
module sprite_config_scheduler #(
    parameter int          N_SPRITES = 5,
    parameter int          X_WIDTH   = 10,
    parameter int          Y_WIDTH   = 9,
    parameter int          DXY_WIDTH = 4,
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SPRITES-1:0] req_xy,
    input  logic [N_SPRITES-1:0] req_dxy,
    input  logic                 hold,
    input  logic [1:0]           difficulty,
    output logic                 busy,
    output logic                 all_done,
    output logic [N_SPRITES-1:0] sprite_write_xy,
    output logic [N_SPRITES-1:0] sprite_write_dxy,
    output logic [X_WIDTH-1:0]   sprite_x,
    output logic [Y_WIDTH-1:0]   sprite_y,
    output logic [DXY_WIDTH-1:0] sprite_dx,
    output logic [DXY_WIDTH-1:0] sprite_dy
);

    localparam logic [X_WIDTH-1:0] SW = X_WIDTH'(SCREEN_W);
    localparam logic [Y_WIDTH-1:0] SH = Y_WIDTH'(SCREEN_H);

    logic [N_SPRITES-1:0] pend_xy;
    logic [N_SPRITES-1:0] pend_dxy;
    logic [N_SPRITES-1:0] gnt_xy;
    logic [N_SPRITES-1:0] gnt_dxy;
    logic [N_SPRITES-1:0] nxt_xy;
    logic [N_SPRITES-1:0] nxt_dxy;
    logic [15:0]          lfsr;
    logic                 fb;
    logic [X_WIDTH-1:0]   x_raw;
    logic [X_WIDTH-1:0]   x_fold;
    logic [Y_WIDTH-1:0]   y_raw;
    logic [Y_WIDTH-1:0]   y_fold;
    logic [DXY_WIDTH-1:0] mag;
    logic [DXY_WIDTH-1:0] dx_nxt;
    logic [DXY_WIDTH-1:0] dy_nxt;
    logic                 any_gnt;

    // x & -x isolates the lowest set bit; xy always outranks dxy
    assign gnt_xy  = hold ? '0 : (pend_xy & (-pend_xy));
    assign gnt_dxy = (hold || (|pend_xy)) ? '0
                   : (pend_dxy & (-pend_dxy));
    assign any_gnt = (|gnt_xy) || (|gnt_dxy);

    assign nxt_xy  = (pend_xy & ~gnt_xy) | req_xy;
    assign nxt_dxy = (pend_dxy & ~gnt_dxy) | req_dxy;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign x_raw  = lfsr[X_WIDTH-1:0];
    assign x_fold = (x_raw >= SW) ? (x_raw - SW) : x_raw;
    assign y_raw  = lfsr[15 -: Y_WIDTH];
    assign y_fold = (y_raw >= SH) ? (y_raw - SH) : y_raw;

    assign mag    = DXY_WIDTH'(difficulty) + DXY_WIDTH'(1);
    assign dx_nxt = lfsr[0] ? (-mag) : mag;
    assign dy_nxt = lfsr[1] ? (-mag) : mag;

    assign busy = (|pend_xy) || (|pend_dxy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_xy          <= '0;
            pend_dxy         <= '0;
            lfsr             <= LFSR_SEED;
            all_done         <= 1'b0;
            sprite_write_xy  <= '0;
            sprite_write_dxy <= '0;
            sprite_x         <= '0;
            sprite_y         <= '0;
            sprite_dx        <= '0;
            sprite_dy        <= '0;
        end else begin
            pend_xy          <= nxt_xy;
            pend_dxy         <= nxt_dxy;
            lfsr             <= {lfsr[14:0], fb};
            sprite_write_xy  <= gnt_xy;
            sprite_write_dxy <= gnt_dxy;
            all_done         <= any_gnt && (nxt_xy == '0)
                                && (nxt_dxy == '0);
            if (|gnt_xy) begin
                sprite_x <= x_fold;
                sprite_y <= y_fold;
            end
            if (|gnt_dxy) begin
                sprite_dx <= dx_nxt;
                sprite_dy <= dy_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sprite_config_scheduler.sv
// Scoreboard bench for sprite_config_scheduler: expected strobes are queued
// at stimulus time and retired by a negedge monitor.
module tb_sprite_config_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req_xy = '0;
    logic [4:0] req_dxy = '0;
    logic       hold = 1'b0;
    logic [1:0] difficulty = '0;
    logic       busy;
    logic       all_done;
    logic [4:0] wxy;
    logic [4:0] wdxy;
    logic [9:0] sx;
    logic [8:0] sy;
    logic [3:0] sdx;
    logic [3:0] sdy;

    sprite_config_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .req_xy           (req_xy),
        .req_dxy          (req_dxy),
        .hold             (hold),
        .difficulty       (difficulty),
        .busy             (busy),
        .all_done         (all_done),
        .sprite_write_xy  (wxy),
        .sprite_write_dxy (wdxy),
        .sprite_x         (sx),
        .sprite_y         (sy),
        .sprite_dx        (sdx),
        .sprite_dy        (sdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_dxy;
        int idx;
        int mag;
    } ent_t;

    ent_t  q[$];
    int    stamps[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    n_xy_seen = 0;
    int    dx_neg, dx_pos, dy_neg, dy_pos;
    logic [15:0] m_cur, m_prev;
    logic [9:0]  last_x = '0;
    logic [8:0]  last_y = '0;
    logic [3:0]  last_dx = '0;
    logic [3:0]  last_dy = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference LFSR: taps 16,14,13,11; m_prev is the value of the grant cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cur  <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_cur;
            m_cur  <= {m_cur[14:0],
                       m_cur[15] ^ m_cur[13] ^ m_cur[12] ^ m_cur[10]};
        end
    end

    ent_t       e;
    logic [4:0] exy, edxy;
    int         ex, ey;
    logic [3:0] edx, edy;

    always @(negedge clk) begin
        if (rst) begin
            if ((|wxy) || (|wdxy)) begin
                stamps.push_back(cyc);
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_strobe xy=%b dxy=%b, none expected",
                             wxy, wdxy);
                end else begin
                    n_pass++;
                    e = q.pop_front();
                    exy  = e.is_dxy ? 5'b0 : 5'(1 << e.idx);
                    edxy = e.is_dxy ? 5'(1 << e.idx) : 5'b0;
                    n_chk++;
                    if ({wxy, wdxy} !== {exy, edxy})
                        $display("FAIL strobe_order got xy=%b dxy=%b want xy=%b dxy=%b",
                                 wxy, wdxy, exy, edxy);
                    else
                        n_pass++;
                    n_chk++;
                    if ({all_done, busy} !== {q.size() == 0, q.size() != 0})
                        $display("FAIL done_busy got done=%b busy=%b want done=%b busy=%b",
                                 all_done, busy, q.size() == 0, q.size() != 0);
                    else
                        n_pass++;
                    if (!e.is_dxy) begin
                        ex = int'(m_prev[9:0]);
                        if (ex >= 640) ex -= 640;
                        ey = int'(m_prev[15:7]);
                        if (ey >= 480) ey -= 480;
                        last_x = 10'(ex);
                        last_y = 9'(ey);
                        n_xy_seen++;
                        n_chk++;
                        if (int'(sx) >= 640 || int'(sy) >= 480)
                            $display("FAIL bounds got x=%0d y=%0d want x<640 y<480",
                                     sx, sy);
                        else
                            n_pass++;
                    end else begin
                        edx = m_prev[0] ? 4'(-e.mag) : 4'(e.mag);
                        edy = m_prev[1] ? 4'(-e.mag) : 4'(e.mag);
                        last_dx = edx;
                        last_dy = edy;
                        if (sdx[3]) dx_neg++; else dx_pos++;
                        if (sdy[3]) dy_neg++; else dy_pos++;
                    end
                    n_chk++;
                    if ({sx, sy, sdx, sdy} !== {last_x, last_y, last_dx, last_dy})
                        $display("FAIL data got x=%0d y=%0d dx=%h dy=%h want x=%0d y=%0d dx=%h dy=%h",
                                 sx, sy, sdx, sdy, last_x, last_y, last_dx, last_dy);
                    else
                        n_pass++;
                end
            end else begin
                n_chk++;
                if (all_done !== 1'b0)
                    $display("FAIL idle_done got %b want 0", all_done);
                else
                    n_pass++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [4:0] rx, input logic [4:0] rd,
                              input int mag);
        ent_t t;
        for (int i = 0; i < 5; i++)
            if (rx[i]) begin
                t.is_dxy = 1'b0; t.idx = i; t.mag = mag;
                q.push_back(t);
            end
        for (int i = 0; i < 5; i++)
            if (rd[i]) begin
                t.is_dxy = 1'b1; t.idx = i; t.mag = mag;
                q.push_back(t);
            end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, all_done, wxy, wdxy, sx, sy, sdx, sdy} !== '0)
            $display("FAIL reset_state got busy=%b done=%b xy=%b dxy=%b x=%0d y=%0d want all 0",
                     busy, all_done, wxy, wdxy, sx, sy);
        else
            n_pass++;
        step();
        rst = 1'b1;
        step();
        req_xy = 5'b11111;
        req_dxy = 5'b11111;
        push_burst(req_xy, req_dxy, 1);
        step();
        req_xy = '0;
        req_dxy = '0;
        repeat (4) step();
        rst = 1'b0;
        #1;
        n_chk++;
        if ({busy, all_done, wxy, wdxy, sx, sy, sdx, sdy} !== '0)
            $display("FAIL reset_midburst got busy=%b done=%b xy=%b dxy=%b x=%0d y=%0d want all 0",
                     busy, all_done, wxy, wdxy, sx, sy);
        else
            n_pass++;
        q.delete();
        last_x = '0; last_y = '0; last_dx = '0; last_dy = '0;
        repeat (2) step();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_chk++;
            if ({wxy, wdxy, busy, all_done} !== '0)
                $display("FAIL post_reset_idle got xy=%b dxy=%b busy=%b done=%b want 0",
                         wxy, wdxy, busy, all_done);
            else
                n_pass++;
        end
    endtask

    task automatic test_single();
        bit ok;
        req_xy = 5'b00100;
        push_burst(req_xy, 5'b0, 1);
        step();
        req_xy = '0;
        n_chk++;
        if ({busy, wxy} !== {1'b1, 5'b0})
            $display("FAIL single_c1 got busy=%b xy=%b want busy=1 xy=00000", busy, wxy);
        else
            n_pass++;
        step();
        n_chk++;
        if ({wxy, all_done, busy} !== {5'b00100, 1'b1, 1'b0})
            $display("FAIL single_c2 got xy=%b done=%b busy=%b want 00100 1 0",
                     wxy, all_done, busy);
        else
            n_pass++;
        step();
        n_chk++;
        if (wxy !== 5'b0)
            $display("FAIL single_c3 got xy=%b want 00000", wxy);
        else
            n_pass++;
        wait_drain(ok);
    endtask

    task automatic test_burst();
        bit ok;
        int c0;
        stamps.delete();
        c0 = cyc;
        req_xy = 5'b11111;
        req_dxy = 5'b00111;
        push_burst(req_xy, req_dxy, 1);
        step();
        req_xy = '0;
        req_dxy = '0;
        wait_drain(ok);
        n_chk++;
        if (!ok || stamps.size() != 8 || stamps[0] != c0 + 2)
            $display("FAIL burst_count got ok=%b n=%0d first=%0d want 1 8 %0d",
                     ok, stamps.size(), stamps.size() ? stamps[0] : -1, c0 + 2);
        else
            n_pass++;
        for (int i = 1; i < stamps.size(); i++) begin
            n_chk++;
            if (stamps[i] - stamps[i-1] != 1)
                $display("FAIL burst_gap got %0d want 1 at %0d",
                         stamps[i] - stamps[i-1], i);
            else
                n_pass++;
        end
    endtask

    task automatic test_hold();
        bit ok;
        int want;
        stamps.delete();
        req_xy = 5'b11111;
        req_dxy = 5'b00111;
        push_burst(req_xy, req_dxy, 1);
        step();
        req_xy = '0;
        req_dxy = '0;
        for (int k = 0; k < 20 && stamps.size() < 2; k++) step();
        hold = 1'b1;
        repeat (3) step();
        hold = 1'b0;
        wait_drain(ok);
        n_chk++;
        if (!ok || stamps.size() != 8)
            $display("FAIL hold_count got ok=%b n=%0d want 1 8", ok, stamps.size());
        else
            n_pass++;
        for (int i = 1; i < stamps.size(); i++) begin
            want = (i == 2) ? 4 : 1;
            n_chk++;
            if (stamps[i] - stamps[i-1] != want)
                $display("FAIL hold_gap got %0d want %0d at %0d",
                         stamps[i] - stamps[i-1], want, i);
            else
                n_pass++;
        end
    endtask

    task automatic test_collision();
        bit ok;
        ent_t t;
        stamps.delete();
        req_xy = 5'b11111;
        req_dxy = 5'b00111;
        push_burst(req_xy, req_dxy, 1);
        step();
        req_dxy = '0;
        req_xy = 5'b00001;
        t.is_dxy = 1'b0; t.idx = 0; t.mag = 1;
        q.insert(1, t);
        step();
        req_xy = '0;
        wait_drain(ok);
        n_chk++;
        if (!ok || stamps.size() != 9)
            $display("FAIL collision_count got ok=%b n=%0d want 1 9", ok, stamps.size());
        else
            n_pass++;
    endtask

    task automatic test_velocity();
        bit ok;
        for (int d = 0; d < 4; d++) begin
            difficulty = 2'(d);
            dx_neg = 0; dx_pos = 0; dy_neg = 0; dy_pos = 0;
            for (int b = 0; b < 40; b++) begin
                req_dxy = 5'b11111;
                push_burst(5'b0, req_dxy, d + 1);
                step();
                req_dxy = '0;
                wait_drain(ok);
                n_chk++;
                if (!ok)
                    $display("FAIL vel_drain got timeout want drained d=%0d", d);
                else
                    n_pass++;
            end
            n_chk++;
            if (dx_neg == 0 || dx_pos == 0 || dy_neg == 0 || dy_pos == 0)
                $display("FAIL vel_signs got dx-%0d dx+%0d dy-%0d dy+%0d want all >0",
                         dx_neg, dx_pos, dy_neg, dy_pos);
            else
                n_pass++;
        end
    endtask

    task automatic test_bounds();
        bit ok;
        n_xy_seen = 0;
        for (int b = 0; b < 200; b++) begin
            req_xy = 5'b11111;
            push_burst(req_xy, 5'b0, 1);
            step();
            req_xy = '0;
            wait_drain(ok);
        end
        n_chk++;
        if (n_xy_seen != 1000)
            $display("FAIL bounds_count got %0d want 1000", n_xy_seen);
        else
            n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_hold();
        test_collision();
        test_velocity();
        test_bounds();
        repeat (10) step();
        n_chk++;
        if (q.size() != 0)
            $display("FAIL leftover got %0d want 0", q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
